fp_addsub_pipe: RTL and testbench
=================================

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23: mantissa field width, hidden bit excluded.
REQ-003 SHALL define the word width W = 1+EXP_W+MAN_W and use the layout {sign, exponent, mantissa}, with the sign in the MSB.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operand pair is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept an operand pair this cycle.
REQ-008 SHALL have port a, input, W bits: operand A.
REQ-009 SHALL have port b, input, W bits: operand B.
REQ-010 SHALL have port sub, input, 1 bit: 1 computes a-b, 0 computes a+b.
REQ-011 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port result, output, W bits: the sum or difference.
REQ-014 SHALL have port ovf, output, 1 bit: result overflowed to infinity.
REQ-015 SHALL have port unf, output, 1 bit: result was flushed to zero.

Function
REQ-016 SHALL accept a transfer when in_valid and in_ready are both high in a cycle; the output transfer occurs when out_valid and out_ready are both high.
REQ-017 SHALL be a 3-stage pipeline: S1 align, S2 add and leading-zero count, S3 normalize, round and pack.
REQ-018 SHALL have a latency of exactly 3 cycles from an input transfer to out_valid when unstalled, with a throughput of one operation per cycle.
REQ-019 SHALL compute the global advance condition adv = !out_valid || out_ready, advance all stages together only when adv is high, and drive in_ready = adv combinationally.
REQ-020 SHALL hold every stage register, result and the flags stable while stalled; no operation is dropped or duplicated.
REQ-021 SHALL propagate bubbles (invalid stages) as valid=0; bubbles are not collapsed.
REQ-022 SHALL use the effective sign of B equal to b sign XOR sub.
REQ-023 SHALL in S1 swap operands so that the larger magnitude is in the X path, taking exponent and then mantissa ordering.
REQ-024 SHALL in S1 right-shift the Y mantissa by the exponent difference, preserving guard and round bits and OR-ing the discarded bits into sticky.
REQ-025 SHALL force the shifted Y mantissa to zero with sticky=1 when the difference is greater than MAN_W+2.
REQ-026 SHALL in S2 form the unsigned magnitude sum or difference of {1,mantissa} values as MAN_W+5 bits (carry, hidden, mantissa, G, R/S); the result sign is the X sign.
REQ-027 SHALL in S3 shift right by 1 and increment the exponent on carry, or shift left by the leading-zero count and decrement the exponent.
REQ-028 SHALL give a result of +0 when the exact difference is zero, regardless of the operand signs.
REQ-029 SHALL treat an exponent field of 0 as zero (denormals flushed); if one operand is zero, the result is the other operand, with its sign adjusted by sub.
REQ-030 SHALL treat an exponent field of all ones as special: Inf±finite gives that Inf; same-sign Inf+Inf gives Inf; Inf−Inf or any NaN input gives canonical NaN {0, all ones, 1000…0}.
REQ-031 SHALL, when the post-normalization exponent is at least 2^EXP_W−1, output signed Inf and set ovf=1.
REQ-032 SHALL, when the post-normalization exponent is at most 0 for a non-zero result, output signed zero and set unf=1.
REQ-033 SHALL assert ovf and unf only together with out_valid; both are 0 otherwise.

Reset
REQ-034 SHALL clear all stage valid bits, out_valid, result, ovf and unf to 0 on rst.
REQ-035 SHALL take priority for rst over any advance; an operation in flight when rst asserts is discarded and never appears on the output.
REQ-036 SHALL have in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-037 SHALL use the macro FP_ADD_RNE_EN: when defined, S3 rounds to nearest-even using G, R and sticky; a mantissa carry-out of rounding renormalizes and increments the exponent, which may set ovf.
REQ-038 SHALL, when FP_ADD_RNE_EN is undefined, truncate (round toward zero) and not use the guard, round or sticky bits; all other behaviour is identical.

Verification
REQ-039 SHALL cover: a=0x3F800000, b=0x3F800000, sub=0 -> result=0x40000000 exactly 3 cycles later, ovf=unf=0.
REQ-040 SHALL cover: a=0x40400000, b=0x3F800000, sub=1 -> 0x40000000; a=0x3F800000, b=0x3F800000, sub=1 -> 0x00000000.
REQ-041 SHALL cover: a=b=0x7F7FFFFF, sub=0 -> result=0x7F800000, ovf=1; a=0x7F800000, b=0x7F800000, sub=1 -> 0x7FC00000.
REQ-042 SHALL cover: a=0x3F800000, b=0x33C00000 -> 0x3F800001 with FP_ADD_RNE_EN and 0x3F800000 without; b=0x33800000 -> 0x3F800000 in both builds.
REQ-043 SHALL cover: stream 6 back-to-back operations while holding out_ready=0 for 4 cycles mid-stream -> in_ready low while stalled, all 6 results emerge in order with no loss or duplicates.
REQ-044 SHALL cover: rst asserted for 1 cycle while 3 operations are in flight -> out_valid=0 the next cycle and none of those results appear afterward.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (align / add+LZC / normalize+round+pack).
// Define FP_ADD_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   ovf,
    output logic                   unf
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int FW  = MAN_W + 4;          // {hidden, mantissa, G, R, S}
    localparam int SW  = MAN_W + 5;          // FW plus carry
    localparam int LZW = $clog2(SW + 1);
    localparam int EW  = EXP_W + 2;

    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [MAN_W-1:0] MAN_ZERO  = '0;
    localparam logic [EXP_W-1:0] SHIFT_MAX = EXP_W'(MAN_W + 2);
    localparam logic [EW-1:0]    E_INF     = {2'b00, EXP_ONES};
    localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: classify, swap, align ----------------
    logic               sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    assign sa = a[W-1];
    assign sb = b[W-1] ^ sub;
    assign ea = a[W-2:MAN_W];
    assign eb = b[W-2:MAN_W];
    assign ma = a[MAN_W-1:0];
    assign mb = b[MAN_W-1:0];
    assign a_nan  = (ea == EXP_ONES) && (ma != MAN_ZERO);
    assign b_nan  = (eb == EXP_ONES) && (mb != MAN_ZERO);
    assign a_inf  = (ea == EXP_ONES) && (ma == MAN_ZERO);
    assign b_inf  = (eb == EXP_ONES) && (mb == MAN_ZERO);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    logic           spec;
    logic [W-1:0]   spec_res;
    always_comb begin
        spec     = 1'b1;
        spec_res = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            spec_res = QNAN;
        else if (a_inf)
            spec_res = {sa, EXP_ONES, MAN_ZERO};
        else if (b_inf)
            spec_res = {sb, EXP_ONES, MAN_ZERO};
        else if (a_zero && b_zero)
            spec_res = {sa & sb, {(W-1){1'b0}}};
        else if (a_zero)
            spec_res = {sb, b[W-2:0]};
        else if (b_zero)
            spec_res = a;
        else
            spec = 1'b0;
    end

    logic               swap, xs, ys;
    logic [EXP_W-1:0]   xe, ye, ediff;
    logic [MAN_W-1:0]   xm, ym;
    assign swap  = {eb, mb} > {ea, ma};
    assign xs    = swap ? sb : sa;
    assign ys    = swap ? sa : sb;
    assign xe    = swap ? eb : ea;
    assign ye    = swap ? ea : eb;
    assign xm    = swap ? mb : ma;
    assign ym    = swap ? ma : mb;
    assign ediff = xe - ye;

    // Lower half of the wide shift collects every bit pushed past S for the sticky OR.
    logic [2*FW-1:0] y_wide;
    logic [FW-1:0]   y_al;
    always_comb begin
        y_wide = {1'b1, ym, 3'b000, {FW{1'b0}}} >> ediff;
        if (ediff > SHIFT_MAX)
            y_al = {{(FW-1){1'b0}}, 1'b1};
        else
            y_al = y_wide[2*FW-1:FW] | {{(FW-1){1'b0}}, |y_wide[FW-1:0]};
    end

    logic               s1_valid, s1_spec, s1_sign, s1_eff_sub;
    logic [W-1:0]       s1_spec_res;
    logic [EXP_W-1:0]   s1_exp;
    logic [FW-1:0]      s1_mx, s1_my;

    // ---------------- S2: magnitude add/sub, leading-zero count ----------------
    logic [SW-1:0]  sum;
    logic [LZW-1:0] lz;
    logic           lz_found;
    always_comb begin
        if (s1_eff_sub)
            sum = {1'b0, s1_mx} - {1'b0, s1_my};
        else
            sum = {1'b0, s1_mx} + {1'b0, s1_my};
        lz       = LZW'(FW);
        lz_found = 1'b0;
        for (int unsigned i = 0; i < FW; i++) begin
            if (!lz_found && sum[FW-1-i]) begin
                lz       = LZW'(i);
                lz_found = 1'b1;
            end
        end
    end

    logic               s2_valid, s2_spec, s2_sign;
    logic [W-1:0]       s2_spec_res;
    logic [EXP_W-1:0]   s2_exp;
    logic [SW-1:0]      s2_sum;
    logic [LZW-1:0]     s2_lz;

    // ---------------- S3: normalize, round, pack ----------------
    logic [FW-1:0]      norm;
    logic [EW-1:0]      e_norm, e_fin;
    logic [MAN_W+1:0]   m_rnd;
    logic [MAN_W-1:0]   m_fin;
    logic               rnd_up;
    logic [W-1:0]       res_n;
    logic               ovf_n, unf_n;

`ifdef FP_ADD_RNE_EN
    assign rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
    logic grs_unused;
    assign grs_unused = |norm[2:0];
    assign rnd_up     = 1'b0;
`endif

    always_comb begin
        if (s2_sum[SW-1]) begin
            norm   = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
            e_norm = {2'b00, s2_exp} + EW'(1);
        end else begin
            norm   = s2_sum[FW-1:0] << s2_lz;
            e_norm = {2'b00, s2_exp} - EW'(s2_lz);
        end
        m_rnd = {1'b0, norm[FW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        if (m_rnd[MAN_W+1]) begin
            e_fin = e_norm + EW'(1);
            m_fin = m_rnd[MAN_W:1];
        end else begin
            e_fin = e_norm;
            m_fin = m_rnd[MAN_W-1:0];
        end
        res_n = '0;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        if (s2_spec)
            res_n = s2_spec_res;
        else if (s2_sum == '0)
            res_n = '0;
        else if (e_fin[EW-1] || (e_fin == '0)) begin
            res_n = {s2_sign, {(W-1){1'b0}}};
            unf_n = 1'b1;
        end else if (e_fin >= E_INF) begin
            res_n = {s2_sign, EXP_ONES, MAN_ZERO};
            ovf_n = 1'b1;
        end else
            res_n = {s2_sign, e_fin[EXP_W-1:0], m_fin};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_spec     <= 1'b0;
            s1_spec_res <= '0;
            s1_sign     <= 1'b0;
            s1_eff_sub  <= 1'b0;
            s1_exp      <= '0;
            s1_mx       <= '0;
            s1_my       <= '0;
            s2_valid    <= 1'b0;
            s2_spec     <= 1'b0;
            s2_spec_res <= '0;
            s2_sign     <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
            s2_lz       <= '0;
            out_valid   <= 1'b0;
            result      <= '0;
            ovf         <= 1'b0;
            unf         <= 1'b0;
        end else if (adv) begin
            s1_valid    <= in_valid;
            s1_spec     <= spec;
            s1_spec_res <= spec_res;
            s1_sign     <= xs;
            s1_eff_sub  <= xs ^ ys;
            s1_exp      <= xe;
            s1_mx       <= {1'b1, xm, 3'b000};
            s1_my       <= y_al;
            s2_valid    <= s1_valid;
            s2_spec     <= s1_spec;
            s2_spec_res <= s1_spec_res;
            s2_sign     <= s1_sign;
            s2_exp      <= s1_exp;
            s2_sum      <= sum;
            s2_lz       <= lz;
            out_valid   <= s2_valid;
            result      <= s2_valid ? res_n : '0;
            ovf         <= s2_valid & ovf_n;
            unf         <= s2_valid & unf_n;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed self-checking bench for fp_addsub_pipe (single-precision defaults).
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sub, out_valid, out_ready, ovf, unf;
    logic [31:0] a, b, result;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic        o;
        logic        u;
    } vec_t;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issues one operation into an idle pipeline and waits (bounded) for its result.
    task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic os,
                         output logic [31:0] r, output logic ro, output logic ru, output int lat);
        @(negedge clk);
        a = oa; b = ob; sub = os; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1; r = '0; ro = 1'b0; ru = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i; r = result; ro = ovf; ru = unf;
                break;
            end
        end
    endtask

    task automatic run_table(input string name, input vec_t v[]);
        logic [31:0] r;
        logic        ro, ru;
        int          lat;
        foreach (v[i]) begin
            do_op(v[i].a, v[i].b, v[i].s, r, ro, ru, lat);
            tests++;
            if (lat !== 3) begin
                fails++;
                $display("FAIL %s[%0d] latency: got %0d expected 3", name, i, lat);
            end
            tests++;
            if (r !== v[i].r) begin
                fails++;
                $display("FAIL %s[%0d] result: got %h expected %h", name, i, r, v[i].r);
            end
            tests++;
            if (ro !== v[i].o || ru !== v[i].u) begin
                fails++;
                $display("FAIL %s[%0d] flags ovf/unf: got %b/%b expected %b/%b",
                         name, i, ro, ru, v[i].o, v[i].u);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || result !== 32'h0 || ovf !== 1'b0 || unf !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b r=%h o=%b u=%b expected 0 0 0 0",
                     out_valid, result, ovf, unf);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_arith;
        vec_t v[];
        v = new[8];
        v[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0};
        v[1] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0};
        v[2] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0};
        v[3] = '{32'h40000000, 32'h3F000000, 1'b1, 32'h3FC00000, 1'b0, 1'b0};
        v[4] = '{32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 1'b0, 1'b0};
        v[5] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        v[6] = '{32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 1'b0, 1'b0};
        v[7] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 1'b0, 1'b1};
        run_table("arith", v);
    endtask

    task automatic test_special;
        vec_t v[];
        v = new[4];
        v[0] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        v[1] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0};
        v[2] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0};
        v[3] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0};
        run_table("special", v);
    endtask

    task automatic test_rounding;
        vec_t v[];
        v = new[2];
`ifdef FP_ADD_RNE_EN
        v[0] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0};
`else
        v[0] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
`endif
        v[1] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
        run_table("round", v);
    endtask

    task automatic test_back_to_back;
        logic [31:0] ia[6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000};
        logic [31:0] ex[6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000};
        logic [31:0] got[$];
        logic [31:0] held;
        int idx = 0, stall_seen = 0, stall_bad = 0, hold_bad = 0, extra = 0;
        bit fire, have_held;
        have_held = 1'b0;
        held = '0;
        for (int c = 0; c < 60 && got.size() < 6; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c < 8);
            if (idx < 6) begin
                in_valid = 1'b1; a = ia[idx]; b = 32'h3F800000; sub = 1'b0;
            end else
                in_valid = 1'b0;
            #1;
            if (out_valid && out_ready) got.push_back(result);
            fire = in_valid && in_ready;
            if (out_valid && !out_ready) begin
                stall_seen++;
                if (in_ready) stall_bad++;
                if (have_held && result !== held) hold_bad++;
                held = result;
                have_held = 1'b1;
            end
            @(posedge clk);
            if (fire) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        tests++;
        if (stall_seen !== 4 || stall_bad !== 0) begin
            fails++;
            $display("FAIL b2b_stall_in_ready: got stalled=%0d in_ready_high=%0d expected 4 0",
                     stall_seen, stall_bad);
        end
        tests++;
        if (hold_bad !== 0) begin
            fails++;
            $display("FAIL b2b_hold: result changed %0d times while stalled, expected 0", hold_bad);
        end
        tests++;
        if (got.size() !== 6 || extra !== 0) begin
            fails++;
            $display("FAIL b2b_count: got %0d results and %0d extras, expected 6 and 0",
                     got.size(), extra);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (i >= got.size()) begin
                fails++;
                $display("FAIL b2b_result[%0d]: got none expected %h", i, ex[i]);
            end else if (got[i] !== ex[i]) begin
                fails++;
                $display("FAIL b2b_result[%0d]: got %h expected %h", i, got[i], ex[i]);
            end
        end
    endtask

    task automatic test_reset_in_flight;
        int seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'h40000000; b = 32'h3F800000; sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_flight_out_valid: got %b expected 0", out_valid);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_flight_in_ready: got %b expected 1", in_ready);
        end
        repeat (10) begin
            @(negedge clk);
            if (out_valid || ovf || unf) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL rst_flight_leak: got %0d output cycles expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_rounding();
        test_back_to_back();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
